// File: rtl/reg_status_bank.sv
// rtl/reg_status_bank.sv - Tomasulo register file with Qi tag table and CDB forwarding
module reg_status_bank #(
  parameter int NREG = 8,
  parameter int DW   = 16,
  parameter int TW   = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [TW+DW-1:0] cdb_in,
  input  logic             cdb_wren,
  input  logic [AW-1:0]    cdb_rd,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd,
  input  logic [TW-1:0]    issue_tag,
  input  logic [AW-1:0]    rs_a,
  input  logic [AW-1:0]    rs_b,
  output logic [DW-1:0]    va,
  output logic [TW-1:0]    qa,
  output logic [DW-1:0]    vb,
  output logic [TW-1:0]    qb,
  input  logic             init_en,
  input  logic [AW-1:0]    init_addr,
  input  logic [DW-1:0]    init_data,
  output logic [NREG-1:0]  busy_mask,
  output logic [7:0]       stale_cnt
);

  logic [DW-1:0] val [NREG];
  logic [TW-1:0] tag [NREG];

  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          cdb_valid;
  logic          cdb_hit;
  logic          cdb_stale;

  assign cdb_tag   = cdb_in[TW+DW-1:DW];
  assign cdb_data  = cdb_in[DW-1:0];
  assign cdb_valid = cdb_wren && (cdb_tag != '0);
  assign cdb_hit   = cdb_valid && (tag[cdb_rd] == cdb_tag);
  // A CDB write swallowed by a same-register init is neither applied nor stale.
  assign cdb_stale = cdb_valid && !cdb_hit && !(init_en && (init_addr == cdb_rd));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < NREG; i++) begin
        val[i] <= '0;
        tag[i] <= '0;
      end
      stale_cnt <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (init_en && (init_addr == AW'(i))) begin
          val[i] <= init_data;
          tag[i] <= '0;
        end else begin
          if (cdb_hit && (cdb_rd == AW'(i))) begin
            val[i] <= cdb_data;
            tag[i] <= '0;
          end
          // Issue rename is applied after the CDB clear so it wins the tag.
          if (issue_en && (issue_tag != '0) && (issue_rd == AW'(i)))
            tag[i] <= issue_tag;
        end
      end
      if (cdb_stale && (stale_cnt != 8'hFF))
        stale_cnt <= stale_cnt + 8'd1;
    end
  end

  always_comb begin
    va = val[rs_a];
    qa = tag[rs_a];
    vb = val[rs_b];
    qb = tag[rs_b];
    if (cdb_valid && (tag[rs_a] == cdb_tag)) begin
      va = cdb_data;
      qa = '0;
    end
    if (cdb_valid && (tag[rs_b] == cdb_tag)) begin
      vb = cdb_data;
      qb = '0;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NREG; i++)
      busy_mask[i] = (tag[i] != '0);
  end

endmodule

// File: tb/tb_reg_status_bank.sv
// tb/tb_reg_status_bank.sv - scoreboard bench for reg_status_bank
module tb_reg_status_bank;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic [19:0] cdb_in = '0;
  logic        cdb_wren = 1'b0;
  logic [2:0]  cdb_rd = '0;
  logic        issue_en = 1'b0;
  logic [2:0]  issue_rd = '0;
  logic [3:0]  issue_tag = '0;
  logic [2:0]  rs_a = '0;
  logic [2:0]  rs_b = '0;
  logic [15:0] va, vb;
  logic [3:0]  qa, qb;
  logic        init_en = 1'b0;
  logic [2:0]  init_addr = '0;
  logic [15:0] init_data = '0;
  logic [7:0]  busy_mask;
  logic [7:0]  stale_cnt;

  reg_status_bank dut (
    .CLK(CLK), .CLR(CLR), .cdb_in(cdb_in), .cdb_wren(cdb_wren), .cdb_rd(cdb_rd),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rs_a(rs_a), .rs_b(rs_b), .va(va), .qa(qa), .vb(vb), .qb(qb),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
    .busy_mask(busy_mask), .stale_cnt(stale_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [15:0] va;
    logic [3:0]  qa;
    logic [15:0] vb;
    logic [3:0]  qb;
    logic [7:0]  busy;
    logic [7:0]  stale;
  } exp_t;

  exp_t exp_q[$];
  logic sample = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   step_id = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
    sample    = 1'b0;
    cdb_wren  = 1'b0;
    cdb_in    = '0;
    issue_en  = 1'b0;
    issue_tag = '0;
    init_en   = 1'b0;
  endtask

  task automatic expect_out(input logic [15:0] e_va, input logic [3:0] e_qa,
                            input logic [15:0] e_vb, input logic [3:0] e_qb,
                            input logic [7:0] e_busy, input logic [7:0] e_stale);
    exp_t e;
    e.id = step_id; e.va = e_va; e.qa = e_qa; e.vb = e_vb; e.qb = e_qb;
    e.busy = e_busy; e.stale = e_stale;
    exp_q.push_back(e);
    step_id++;
    sample = 1'b1;
  endtask

  task automatic cmp(input int id, input string what, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL step%0d %s actual=%h required=%h", id, what, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (sample) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard underflow actual=0 required=1");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.id, "va", va, e.va);
        cmp(e.id, "qa", {12'h0, qa}, {12'h0, e.qa});
        cmp(e.id, "vb", vb, e.vb);
        cmp(e.id, "qb", {12'h0, qb}, {12'h0, e.qb});
        cmp(e.id, "busy_mask", {8'h0, busy_mask}, {8'h0, e.busy});
        cmp(e.id, "stale_cnt", {8'h0, stale_cnt}, {8'h0, e.stale});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    rs_a = 3'd0; rs_b = 3'd0;
    expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd0);           // reset state
    tick();
    CLR = 1'b0;
    init_en = 1'b1; init_addr = 3'd3; init_data = 16'h1234;
    rs_a = 3'd3; rs_b = 3'd3;
    expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd0);
    tick();
    issue_en = 1'b1; issue_rd = 3'd3; issue_tag = 4'd5;
    rs_a = 3'd3; rs_b = 3'd0;
    expect_out(16'h1234, 4'h0, 16'h0, 4'h0, 8'h00, 8'd0);        // rename not visible yet
    tick();
    expect_out(16'h1234, 4'h5, 16'h0, 4'h0, 8'h08, 8'd0);
    tick();
    cdb_wren = 1'b1; cdb_in = {4'd5, 16'hBEEF}; cdb_rd = 3'd3;
    rs_b = 3'd3;
    expect_out(16'hBEEF, 4'h0, 16'hBEEF, 4'h0, 8'h08, 8'd0);     // forwarding
    tick();
    expect_out(16'hBEEF, 4'h0, 16'hBEEF, 4'h0, 8'h00, 8'd0);
    // WAW on r2
    tick();
    issue_en = 1'b1; issue_rd = 3'd2; issue_tag = 4'd4;
    rs_a = 3'd2; rs_b = 3'd3;
    expect_out(16'h0, 4'h0, 16'hBEEF, 4'h0, 8'h00, 8'd0);
    tick();
    issue_en = 1'b1; issue_rd = 3'd2; issue_tag = 4'd7;
    expect_out(16'h0, 4'h4, 16'hBEEF, 4'h0, 8'h04, 8'd0);
    tick();
    cdb_wren = 1'b1; cdb_in = {4'd4, 16'h0011}; cdb_rd = 3'd2;
    expect_out(16'h0, 4'h7, 16'hBEEF, 4'h0, 8'h04, 8'd0);
    tick();
    cdb_wren = 1'b1; cdb_in = {4'd7, 16'h0022}; cdb_rd = 3'd2;
    expect_out(16'h0022, 4'h0, 16'hBEEF, 4'h0, 8'h04, 8'd1);
    tick();
    rs_b = 3'd2;
    expect_out(16'h0022, 4'h0, 16'h0022, 4'h0, 8'h00, 8'd1);
    // Same-cycle issue + CDB on r1
    tick();
    issue_en = 1'b1; issue_rd = 3'd1; issue_tag = 4'd6;
    rs_a = 3'd1; rs_b = 3'd1;
    expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd1);
    tick();
    issue_en = 1'b1; issue_rd = 3'd1; issue_tag = 4'd9;
    cdb_wren = 1'b1; cdb_in = {4'd6, 16'hAAAA}; cdb_rd = 3'd1;
    expect_out(16'hAAAA, 4'h0, 16'hAAAA, 4'h0, 8'h02, 8'd1);
    tick();
    init_en = 1'b1; init_addr = 3'd1; init_data = 16'h5555;
    issue_en = 1'b1; issue_rd = 3'd1; issue_tag = 4'd3;
    expect_out(16'hAAAA, 4'h9, 16'hAAAA, 4'h9, 8'h02, 8'd1);
    tick();
    expect_out(16'h5555, 4'h0, 16'h5555, 4'h0, 8'h00, 8'd1);
    // Init beats a matching CDB write, no stale count
    tick();
    issue_en = 1'b1; issue_rd = 3'd4; issue_tag = 4'd2;
    rs_a = 3'd4; rs_b = 3'd1;
    expect_out(16'h0, 4'h0, 16'h5555, 4'h0, 8'h00, 8'd1);
    tick();
    init_en = 1'b1; init_addr = 3'd4; init_data = 16'h0404;
    cdb_wren = 1'b1; cdb_in = {4'd2, 16'h9999}; cdb_rd = 3'd4;
    expect_out(16'h9999, 4'h0, 16'h5555, 4'h0, 8'h10, 8'd1);
    tick();
    expect_out(16'h0404, 4'h0, 16'h5555, 4'h0, 8'h00, 8'd1);
    // issue_tag 0 and CDB tag 0 are no-ops
    tick();
    issue_en = 1'b1; issue_rd = 3'd5; issue_tag = 4'd0;
    rs_a = 3'd5; rs_b = 3'd5;
    expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd1);
    tick();
    cdb_wren = 1'b1; cdb_in = {4'd0, 16'hFFFF}; cdb_rd = 3'd5;
    expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd1);
    tick();
    expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd1);
    // 300 stale writes to idle r6
    rs_a = 3'd6; rs_b = 3'd6;
    for (int k = 0; k < 300; k++) begin
      tick();
      cdb_wren = 1'b1; cdb_in = {4'd1, 16'h00FF}; cdb_rd = 3'd6;
      if (k == 100)
        expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd101);
      else if (k == 254 || k == 299)
        expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd255);
    end
    tick();
    expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd255);
    // Tag every register, then reset mid-stream
    for (int i = 0; i < 8; i++) begin
      tick();
      issue_en = 1'b1; issue_rd = 3'(i); issue_tag = 4'(i + 1);
    end
    tick();
    rs_a = 3'd7; rs_b = 3'd0;
    expect_out(16'h0, 4'h8, 16'h0, 4'h1, 8'hFF, 8'd255);
    tick();
    CLR = 1'b1;
    rs_a = 3'd3; rs_b = 3'd2;
    expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd0);
    tick();
    CLR = 1'b0;
    expect_out(16'h0, 4'h0, 16'h0, 4'h0, 8'h00, 8'd0);
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_status_bank.md
Name: reg_status_bank

Overview:
Register file plus register-status (Qi) table that sits directly downstream of the CDB arbiter in the Tomasulo core.
- Holds the architectural values of the 8 general registers and the reservation-station tag that will produce each one.
- Consumes the arbiter's CDB word, write-enable and destination register.
- Gives the issue stage operand values or pending tags, with same-cycle CDB forwarding.

Parameters:
NREG, 8, number of architectural registers (index width 3)
DW, 16, data width
TW, 4, reservation-station tag width; tag 0 = "no producer / value valid"

Ports:
CLK  input  1  clock; all state updates on posedge
CLR  input  1  reset, asynchronous, active-high
cdb_in  input  20  CDB word from arbiter: [19:16] producing tag, [15:0] data
cdb_wren  input  1  CDB write strobe from arbiter (driven on negedge, stable at posedge)
cdb_rd  input  3  destination register carried with the CDB word
issue_en  input  1  issue stage renames a destination this cycle
issue_rd  input  3  register being renamed
issue_tag  input  4  reservation-station tag now owning issue_rd
rs_a  input  3  operand A register index
rs_b  input  3  operand B register index
va  output  16  operand A value (valid when qa==0)
qa  output  4  operand A pending tag (0 = ready)
vb  output  16  operand B value
qb  output  4  operand B pending tag
init_en  input  1  preload strobe (bench/boot)
init_addr  input  3  preload register
init_data  input  16  preload value
busy_mask  output  8  bit i = 1 when tag[i] != 0
stale_cnt  output  8  count of CDB writes dropped as stale, saturating

Behaviour:
- Reset (CLR high, async): all values = 0, all tags = 0, stale_cnt = 0. Hence busy_mask = 0, va/vb = 0, qa/qb = 0. Reset mid-operation drops all pending tags immediately.
- State: val[0..7] (16 b), tag[0..7] (4 b). busy_mask is decoded from tag and has no extra latency.
- CDB write, posedge, valid when cdb_wren=1 and cdb_in[19:16] != 0:
  - tag[cdb_rd] == cdb_in[19:16]: val[cdb_rd] <= cdb_in[15:0]; tag[cdb_rd] <= 0.
  - tag[cdb_rd] != cdb_in[19:16] (register renamed later, WAW) or tag[cdb_rd] == 0: no register change; stale_cnt increments, saturating at 255.
  - cdb_wren=1 with tag 0: ignored entirely, no count.
- Issue, posedge, when issue_en=1 and issue_tag != 0: tag[issue_rd] <= issue_tag. issue_tag == 0 is ignored (no-op).
- Issue and matching CDB to the same register in the same cycle:
  - val takes the CDB data.
  - tag takes issue_tag (issue wins the tag).
  - Not counted as stale.
- Init, posedge, when init_en=1: val[init_addr] <= init_data; tag[init_addr] <= 0. Highest priority: an issue or CDB update to the same register in that cycle is dropped, and no stale count is taken.
- Updates to different registers in the same cycle (init, issue, CDB) all take effect independently.
- Read ports, combinational, with CDB forwarding:
  - If cdb_wren=1, cdb_in[19:16] != 0 and tag[rs_x] == cdb_in[19:16]: output data = cdb_in[15:0], tag = 0.
  - Otherwise output val[rs_x] and tag[rs_x].
  - rs_a == rs_b is legal; both ports return identical results.
  - Reads never see a same-cycle issue rename: the issuing instruction reads its sources before its own rename.
- Latency: a CDB value is visible on va/vb in the same cycle via forwarding, and from the register after the next posedge.

Test Plan:
- Reset, then init r3=0x1234, read rs_a=3 -> va=0x1234, qa=0, busy_mask=0x00.
- Issue r3 tag 5; next cycle read r3 -> qa=5, busy_mask=0x08. Then CDB {tag 5, 0xBEEF}, rd=3 -> same cycle va=0xBEEF, qa=0; after posedge r3=0xBEEF, busy_mask=0x00.
- WAW: issue r2 tag 4, then issue r2 tag 7, then CDB {4, 0x0011} rd=2 -> r2 unchanged, tag stays 7, stale_cnt=1. Then CDB {7, 0x0022} -> r2=0x0022, tag 0.
- Same cycle: r1 tagged 6; issue r1 tag 9 while CDB {6, 0xAAAA} rd=1 -> r1 val=0xAAAA, tag=9, stale_cnt unchanged. init_en on r1 with a simultaneous issue -> r1=init_data, tag 0.
- Edge cases:
  - issue_tag=0 -> no change.
  - CDB tag 0 with wren -> no change, no count.
  - 300 stale writes -> stale_cnt=255.
  - CLR asserted mid-stream with busy_mask=0xFF -> immediately 0x00, stale_cnt=0.
